// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//
// Shares one CPU-style memory port between two masters (for example an
// instruction-fetch port and a data/DMA port). Every side uses the same
// four-phase enable/ready handshake:
//   1. The requester raises enable, with the command held stable.
//   2. The responder raises ready.
//   3. The requester drops enable.
//   4. The responder drops ready.
//
// The arbiter picks a winner, latches that master's command onto the memory_*
// outputs, and runs exactly one downstream transaction. It then returns the
// read data and ready to the winner. Every output is a flop; no input reaches
// an output combinationally.
//
// Parameters
//   FIXED_PRIORITY  0: round-robin on a tie; 1: master 0 always wins a tie.
//
// Ports
//   clock, reset                    clock; asynchronous active-high reset
//   mN_address[31:0]                request byte address
//   mN_data_out[31:0]               write data
//   mN_data_size[1:0]               0 = byte, 1 = half, 2 = word
//   mN_enable, mN_operation         request strobe; 0 = read, 1 = write
//   mN_data_in[31:0], mN_ready      registered read data and completion strobe
//   memory_address/data_out/
//     data_size/operation           latched command of the granted master
//   memory_enable                   downstream request strobe
//   memory_data_in, memory_ready    downstream read data and completion
//   grant[1:0]                      one-hot owner {m1, m0}; 00 when idle
// -----------------------------------------------------------------------------
module memory_arbiter #(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic        clock,
    input  logic        reset,

    input  logic [31:0] m0_address,
    input  logic [31:0] m0_data_out,
    input  logic [1:0]  m0_data_size,
    input  logic        m0_enable,
    input  logic        m0_operation,
    output logic [31:0] m0_data_in,
    output logic        m0_ready,

    input  logic [31:0] m1_address,
    input  logic [31:0] m1_data_out,
    input  logic [1:0]  m1_data_size,
    input  logic        m1_enable,
    input  logic        m1_operation,
    output logic [31:0] m1_data_in,
    output logic        m1_ready,

    output logic [31:0] memory_address,
    output logic [31:0] memory_data_out,
    output logic [1:0]  memory_data_size,
    output logic        memory_enable,
    output logic        memory_operation,
    input  logic [31:0] memory_data_in,
    input  logic        memory_ready,

    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t state_reg;
    logic   last_grant_reg;   // index of the master granted most recently
    logic   owner_reg;        // index of the master owning the current transaction

    logic   req_m0;
    logic   req_m1;
    logic   pick_m1;
    logic   owner_enable;

    // A master whose ready is still high is in its own release phase, so it
    // does not count as a new request.
    assign req_m0 = m0_enable & ~m0_ready;
    assign req_m1 = m1_enable & ~m1_ready;

    always_comb begin
        pick_m1 = 1'b0;
        if (req_m0 && req_m1) begin
            if (FIXED_PRIORITY != 0) begin
                pick_m1 = 1'b0;
            end else begin
                // Round-robin: on a tie, the master not served last time wins.
                pick_m1 = ~last_grant_reg;
            end
        end else begin
            pick_m1 = req_m1;
        end
    end

    assign owner_enable = owner_reg ? m1_enable : m0_enable;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            last_grant_reg   <= 1'b1;   // master 0 wins the first tie
            owner_reg        <= 1'b0;
            grant            <= 2'b00;
            m0_data_in       <= 32'h0;
            m0_ready         <= 1'b0;
            m1_data_in       <= 32'h0;
            m1_ready         <= 1'b0;
            memory_address   <= 32'h0;
            memory_data_out  <= 32'h0;
            memory_data_size <= 2'b00;
            memory_enable    <= 1'b0;
            memory_operation <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Do not start a new transaction while the responder is
                    // still finishing an earlier one, for example after a
                    // reset in mid-transaction.
                    if (!memory_ready && (req_m0 || req_m1)) begin
                        owner_reg        <= pick_m1;
                        last_grant_reg   <= pick_m1;
                        grant            <= pick_m1 ? 2'b10 : 2'b01;
                        memory_address   <= pick_m1 ? m1_address   : m0_address;
                        memory_data_out  <= pick_m1 ? m1_data_out  : m0_data_out;
                        memory_data_size <= pick_m1 ? m1_data_size : m0_data_size;
                        memory_operation <= pick_m1 ? m1_operation : m0_operation;
                        memory_enable    <= 1'b1;
                        state_reg        <= ACCESS;
                    end
                end

                ACCESS: begin
                    // The command stays latched. If the owner drops enable
                    // here, the downstream transaction still completes.
                    if (memory_ready) begin
                        if (!memory_operation) begin
                            if (owner_reg) begin
                                m1_data_in <= memory_data_in;
                            end else begin
                                m0_data_in <= memory_data_in;
                            end
                        end
                        if (owner_reg) begin
                            m1_ready <= 1'b1;
                        end else begin
                            m0_ready <= 1'b1;
                        end
                        memory_enable <= 1'b0;
                        state_reg     <= RESPOND;
                    end
                end

                RESPOND: begin
                    // Both handshakes must be released on the same edge. The
                    // two falls may happen in either order.
                    if (!owner_enable && !memory_ready) begin
                        m0_ready  <= 1'b0;
                        m1_ready  <= 1'b0;
                        grant     <= 2'b00;
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-master arbiter that shares the single CPU-style memory port (address, data in/out, size, enable, operation, ready) between two requesters, e.g. an instruction-fetch port and a data/DMA port. It sits between the masters and the RAM/MMIO responder. It speaks the same four-phase enable/ready handshake on every side. It latches the winning command, runs one downstream transaction, and returns read data and ready to the winner.

## Interface
Parameters:
- FIXED_PRIORITY, 0: 0 selects round-robin; 1 means master 0 always wins a tie.

Ports:
- clock  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces the reset state immediately.
- m0_address / m1_address  in  32  request byte address.
- m0_data_out / m1_data_out  in  32  write data; byte in [7:0], half in [15:0].
- m0_data_size / m1_data_size  in  2  0 = byte, 1 = half, 2 = word.
- m0_enable / m1_enable  in  1  request strobe (four-phase).
- m0_operation / m1_operation  in  1  0 = read, 1 = write.
- m0_data_in / m1_data_in  out  32  registered read data for that master.
- m0_ready / m1_ready  out  1  transaction-complete strobe for that master.
- memory_address  out  32  latched address of the granted master.
- memory_data_out  out  32  latched write data.
- memory_data_size  out  2  latched size.
- memory_enable  out  1  downstream request strobe.
- memory_operation  out  1  latched operation.
- memory_data_in  in  32  downstream read data; valid while memory_ready = 1.
- memory_ready  in  1  downstream completion.
- grant  out  2  one-hot owner ({m1, m0}); 00 when idle.

## Operation
- Reset state:
  - State is IDLE.
  - All outputs are 0.
  - last_grant = 1, so master 0 wins the first tie.
- Four-phase rule on every side:
  - Requester raises enable with the command stable.
  - Responder raises ready.
  - Requester drops enable.
  - Responder drops ready.
- State machine (IDLE, ACCESS, RESPOND):
  - **IDLE:**
    - A master is requesting when its enable = 1 and its ready = 0.
    - A grant is issued only if memory_ready = 0.
    - If exactly one master requests, grant it.
    - If both request:
      - FIXED_PRIORITY = 1: master 0 wins.
      - FIXED_PRIORITY = 0: the master != last_grant wins.
    - On grant:
      - Latch that master's address, data_out, size and operation onto the memory_* outputs.
      - Set memory_enable = 1, set grant, update last_grant.
      - Go to ACCESS.
  - **ACCESS:**
    - Hold all memory_* outputs stable.
    - On an edge with memory_ready = 1:
      - If operation = read, capture memory_data_in into the winner's data_in.
      - Set the winner's ready = 1 and memory_enable = 0.
      - Go to RESPOND.
  - **RESPOND:**
    - On an edge with winner enable = 0 and memory_ready = 0:
      - Clear the winner's ready and grant.
      - Go to IDLE.
    - Both conditions must be true on the same edge; either order of the falls is accepted.
- Read data is not masked or sign-extended; unused upper bytes pass through as delivered.
- mN_data_in:
  - Updates only on a read completion for master N.
  - Writes leave it unchanged.
- The losing master's enable is ignored until it wins. Its ready stays 0.
- A master that drops enable before it is granted is simply not served.
- An enable drop during ACCESS is a protocol violation by the master. The arbiter completes the downstream transaction anyway.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Request-to-grant latency:
  - Request sampled at edge N: memory_enable = 1 after edge N.
  - Responder ready sampled at edge N+k: mN_ready = 1 after that edge.
- Minimum cycle count:
  - 3 edges per transaction (grant, complete, release).
  - The next grant is possible on the 4th edge.
- No back-to-back grant without passing through IDLE.
- Reset mid-operation:
  - All outputs drop asynchronously and the state returns to IDLE.
  - If the responder still holds memory_ready = 1, no new grant is made until it falls.

## Test plan
- Single read: m0 reads word at 0x100 and the responder returns 0xDEADBEEF. Required response:
  - memory_enable rises one edge after m0_enable.
  - memory_address = 0x100, memory_data_size = 2.
  - m0_data_in = 0xDEADBEEF with m0_ready = 1.
  - Release completes after both enables/readys fall; grant = 01, then 00.
- Tie, round-robin: m0 and m1 request on the same edge, repeatedly, with FIXED_PRIORITY = 0.
  - Required grant order: m0, m1, m0, m1.
  - With FIXED_PRIORITY = 1, the order is m0, m0, m0.
- Write passthrough: m1 writes half 0xABCD to 0x42 (operation = 1, size = 1) while m0 holds a pending read. Required response:
  - memory_* shows 0x42 / 0x0000ABCD / 1 / 1.
  - m0 is served after m1 releases.
  - m1_data_in is unchanged.
- Slow responder: memory_ready is delayed 5 cycles.
  - Required: memory_address and memory_enable are held stable for all 5 cycles.
  - Required: m0_ready rises exactly one edge after memory_ready.
- Release order: the master drops enable before the responder drops ready, and vice versa.
  - Required in both cases: IDLE is reached only on the edge where both are 0.
- Reset in ACCESS: assert reset while memory_ready = 0 and keep memory_ready low; then drive memory_ready = 1 with a request pending. Required response:
  - All outputs are 0 immediately on reset.
  - With memory_ready = 1 after reset, no grant is issued.
  - The grant is issued on the first edge after memory_ready falls.
